// File: rtl/nova_tohost_mailbox.sv
// nova_tohost_mailbox
//   AXI4-Lite responder on the BAR1 window that terminates host accesses to
//   the Nova core's to-host mailbox. It holds the 32-bit to-host register,
//   which the host and the core can both write, and a status register. It
//   also sequences the core reset release from virtual DIP bit 0.
//
//   Host flow: load the program into DDR, write 0xDEADBEEF to to-host, raise
//   vdip[0], then poll to-host until the core clears it to 0.
//
// Parameters
//   TOHOST_ADDR : byte address of to-host; status at +4 (from-host at +8)
//   RST_DELAY   : cycles core_rst stays asserted in COUNT (1..65535)
//
// Ports
//   clk_main_a0, rst_main          : clock, async active-high reset
//   s_aw*, s_w*, s_b*              : AXI4-Lite write address/data/response
//   s_ar*, s_r*                    : AXI4-Lite read address/data
//   vdip[15:0]                     : virtual DIP switches, bit 0 releases core
//   core_tohost_we/_wdata          : core full-word write of to-host
//   core_tohost                    : current to-host value
//   core_rst                       : active-high reset to the Nova core
//   core_fromhost, core_fromhost_clr : only with NOVA_MAILBOX_FROMHOST_EN
//
// Optional feature macro: NOVA_MAILBOX_FROMHOST_EN adds a from-host R/W
// register at TOHOST_ADDR+8. Without it, +8 decodes as unmapped.

module nova_tohost_mailbox #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0008_C120,
    parameter int unsigned RST_DELAY   = 16
) (
    input  logic        clk_main_a0,
    input  logic        rst_main,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [15:0] vdip,
    input  logic        core_tohost_we,
    input  logic [31:0] core_tohost_wdata,
    output logic [31:0] core_tohost,
`ifdef NOVA_MAILBOX_FROMHOST_EN
    output logic [31:0] core_fromhost,
    input  logic        core_fromhost_clr,
`endif
    output logic        core_rst
);

    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_RESP  = 1'b1;
    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_DATA  = 1'b1;
    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam logic [29:0] A_TOHOST   = TOHOST_ADDR[31:2];
    localparam logic [29:0] A_STATUS   = A_TOHOST + 30'd1;
`ifdef NOVA_MAILBOX_FROMHOST_EN
    localparam logic [29:0] A_FROMHOST = A_TOHOST + 30'd2;
`endif
    localparam logic [15:0] CNT_LAST   = 16'(RST_DELAY - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_alive;
    logic [0:0]  r_wstate;
    logic        r_aw_held;
    logic        r_w_held;
    logic [29:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic [0:0]  r_rstate;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] r_tohost;
    logic        r_coll;
    logic        r_vdip_s1;
    logic        r_vdip_s2;
    logic [1:0]  r_seq;
    logic [15:0] r_cnt;
`ifdef NOVA_MAILBOX_FROMHOST_EN
    logic [31:0] r_fromhost;
`endif

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_have;
    logic        w_w_have;
    logic [29:0] w_waddr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_commit;
    logic        w_wr_tohost;
    logic        w_wr_status;
    logic        w_wr_mapped;
    logic        w_core_rst;
    logic        w_core_we;
    logic [31:0] w_tohost_merged;
    logic [31:0] w_status;
    logic        w_ar_hs;
    logic [31:0] w_rdata_next;
    logic [1:0]  w_rresp_next;
`ifdef NOVA_MAILBOX_FROMHOST_EN
    logic        w_wr_fromhost;
    logic [31:0] w_fromhost_merged;
`endif
    logic        w_unused;

    assign w_unused = &{1'b0, s_awaddr[1:0], s_araddr[1:0], vdip[15:1]};

    // ------------------------------------------------------------------
    // Handshake outputs; readies stay low until the first clock after reset
    // ------------------------------------------------------------------
    assign s_awready = r_alive & (r_wstate == W_IDLE) & ~r_aw_held;
    assign s_wready  = r_alive & (r_wstate == W_IDLE) & ~r_w_held;
    assign s_bvalid  = (r_wstate == W_RESP);
    assign s_bresp   = r_bresp;
    assign s_arready = r_alive & (r_rstate == R_IDLE);
    assign s_rvalid  = (r_rstate == R_DATA);
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

    assign w_core_rst  = (r_seq != S_RUN);
    assign core_rst    = w_core_rst;
    assign core_tohost = r_tohost;
    assign w_core_we   = core_tohost_we & ~w_core_rst;
    assign w_status    = {30'd0, r_coll, w_core_rst};

    // ------------------------------------------------------------------
    // Write decode: the commit happens on the edge of the later handshake,
    // so the channel that completes now is taken straight from the bus.
    // ------------------------------------------------------------------
    assign w_aw_hs   = s_awvalid & s_awready;
    assign w_w_hs    = s_wvalid & s_wready;
    assign w_aw_have = r_aw_held | w_aw_hs;
    assign w_w_have  = r_w_held | w_w_hs;
    assign w_waddr   = r_aw_held ? r_awaddr : s_awaddr[31:2];
    assign w_wdata   = r_w_held ? r_wdata : s_wdata;
    assign w_wstrb   = r_w_held ? r_wstrb : s_wstrb;
    assign w_commit  = (r_wstate == W_IDLE) & w_aw_have & w_w_have;

    assign w_wr_tohost = w_commit & (w_waddr == A_TOHOST);
    assign w_wr_status = w_commit & (w_waddr == A_STATUS);
`ifdef NOVA_MAILBOX_FROMHOST_EN
    assign w_wr_fromhost = w_commit & (w_waddr == A_FROMHOST);
    assign w_wr_mapped   = w_wr_tohost | w_wr_status | w_wr_fromhost;
`else
    assign w_wr_mapped   = w_wr_tohost | w_wr_status;
`endif

    always_comb begin
        w_tohost_merged = r_tohost;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_wstrb[i]) w_tohost_merged[8*i +: 8] = w_wdata[8*i +: 8];
        end
    end

`ifdef NOVA_MAILBOX_FROMHOST_EN
    always_comb begin
        w_fromhost_merged = r_fromhost;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_wstrb[i]) w_fromhost_merged[8*i +: 8] = w_wdata[8*i +: 8];
        end
    end
`endif

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) r_alive <= 1'b0;
        else          r_alive <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write path FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bresp   <= w_wr_mapped ? 2'b00 : 2'b10;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= s_awaddr[31:2];
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s_wdata;
                            r_wstrb  <= s_wstrb;
                        end
                    end
                end
                default: begin
                    if (s_bready) r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers; host write beats a same-cycle core write and flags it.
    // A new collision takes priority over a write-1-to-clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            r_tohost <= '0;
            r_coll   <= 1'b0;
        end else begin
            if (w_wr_tohost)    r_tohost <= w_tohost_merged;
            else if (w_core_we) r_tohost <= core_tohost_wdata;

            if (w_wr_tohost & w_core_we)                  r_coll <= 1'b1;
            else if (w_wr_status & w_wstrb[0] & w_wdata[1]) r_coll <= 1'b0;
        end
    end

`ifdef NOVA_MAILBOX_FROMHOST_EN
    assign core_fromhost = r_fromhost;

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main)               r_fromhost <= '0;
        else if (w_wr_fromhost)     r_fromhost <= w_fromhost_merged;
        else if (core_fromhost_clr) r_fromhost <= '0;
    end
`endif

    // ------------------------------------------------------------------
    // Read path FSM; data sampled from the registers at the AR handshake
    // ------------------------------------------------------------------
    assign w_ar_hs = s_arvalid & s_arready;

    always_comb begin
        w_rdata_next = '0;
        w_rresp_next = 2'b10;
        if (s_araddr[31:2] == A_TOHOST) begin
            w_rdata_next = r_tohost;
            w_rresp_next = 2'b00;
        end else if (s_araddr[31:2] == A_STATUS) begin
            w_rdata_next = w_status;
            w_rresp_next = 2'b00;
        end
`ifdef NOVA_MAILBOX_FROMHOST_EN
        else if (s_araddr[31:2] == A_FROMHOST) begin
            w_rdata_next = r_fromhost;
            w_rresp_next = 2'b00;
        end
`endif
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_DATA;
                        r_rdata  <= w_rdata_next;
                        r_rresp  <= w_rresp_next;
                    end
                end
                default: begin
                    if (s_rready) r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Core reset sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            r_vdip_s1 <= 1'b0;
            r_vdip_s2 <= 1'b0;
            r_seq     <= S_HOLD;
            r_cnt     <= '0;
        end else begin
            r_vdip_s1 <= vdip[0];
            r_vdip_s2 <= r_vdip_s1;
            if (!r_vdip_s2) begin
                r_seq <= S_HOLD;
                r_cnt <= '0;
            end else begin
                case (r_seq)
                    S_HOLD: begin
                        r_seq <= S_COUNT;
                        r_cnt <= '0;
                    end
                    S_COUNT: begin
                        if (r_cnt == CNT_LAST) r_seq <= S_RUN;
                        else                   r_cnt <= r_cnt + 16'd1;
                    end
                    default: r_seq <= S_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nova_tohost_mailbox.sv
module tb_nova_tohost_mailbox;

    localparam int          RST_DELAY = 16;
    localparam logic [31:0] TA        = 32'h0008_C120;

    logic        clk;
    logic        rst;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [15:0] vdip;
    logic        core_tohost_we;
    logic [31:0] core_tohost_wdata;
    logic [31:0] core_tohost;
    logic        core_rst;
`ifdef NOVA_MAILBOX_FROMHOST_EN
    logic [31:0] core_fromhost;
    logic        core_fromhost_clr;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_tohost;
    logic        m_coll;
    logic        m_core_rst;
    logic [31:0] m_fromhost;

    nova_tohost_mailbox #(
        .TOHOST_ADDR(TA),
        .RST_DELAY  (RST_DELAY)
    ) dut (
        .clk_main_a0      (clk),
        .rst_main         (rst),
        .s_awaddr         (s_awaddr),
        .s_awvalid        (s_awvalid),
        .s_awready        (s_awready),
        .s_wdata          (s_wdata),
        .s_wstrb          (s_wstrb),
        .s_wvalid         (s_wvalid),
        .s_wready         (s_wready),
        .s_bresp          (s_bresp),
        .s_bvalid         (s_bvalid),
        .s_bready         (s_bready),
        .s_araddr         (s_araddr),
        .s_arvalid        (s_arvalid),
        .s_arready        (s_arready),
        .s_rdata          (s_rdata),
        .s_rresp          (s_rresp),
        .s_rvalid         (s_rvalid),
        .s_rready         (s_rready),
        .vdip             (vdip),
        .core_tohost_we   (core_tohost_we),
        .core_tohost_wdata(core_tohost_wdata),
        .core_tohost      (core_tohost),
`ifdef NOVA_MAILBOX_FROMHOST_EN
        .core_fromhost    (core_fromhost),
        .core_fromhost_clr(core_fromhost_clr),
`endif
        .core_rst         (core_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Expected read result derived from the register map rules
    task automatic exp_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        d = 32'h0;
        r = 2'b10;
        if (w == TA) begin
            d = m_tohost; r = 2'b00;
        end else if (w == TA + 32'd4) begin
            d = {30'd0, m_coll, m_core_rst}; r = 2'b00;
        end
`ifdef NOVA_MAILBOX_FROMHOST_EN
        else if (w == TA + 32'd8) begin
            d = m_fromhost; r = 2'b00;
        end
`endif
    endtask

    // Model update for a committed host write; returns the expected bresp
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                               output logic [1:0] r);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        r = 2'b10;
        if (w == TA) begin
            m_tohost = merge(m_tohost, d, st); r = 2'b00;
        end else if (w == TA + 32'd4) begin
            if (st[0] && d[1]) m_coll = 1'b0;
            r = 2'b00;
        end
`ifdef NOVA_MAILBOX_FROMHOST_EN
        else if (w == TA + 32'd8) begin
            m_fromhost = merge(m_fromhost, d, st); r = 2'b00;
        end
`endif
    endtask

    // Drive AW and/or W valid until every requested channel handshakes
    task automatic hs(input logic do_aw, input logic do_w);
        logic pa, pw, ra, rw;
        int n;
        pa = do_aw; pw = do_w; n = 0;
        s_awvalid = pa; s_wvalid = pw;
        while ((pa || pw) && n < 64) begin
            ra = s_awready; rw = s_wready;
            tick();
            n++;
            if (pa && ra) begin pa = 1'b0; s_awvalid = 1'b0; end
            if (pw && rw) begin pw = 1'b0; s_wvalid = 1'b0; end
        end
        if (pa || pw) begin
            checks++; errors++;
            $display("FAIL write_handshake_timeout: aw pending %0b w pending %0b after %0d cycles", pa, pw, n);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
    endtask

    // order: 0 same cycle, 1 W first, 2 AW first
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int order, output logic [1:0] resp, output logic bv_now,
                             output logic [31:0] th_now);
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        case (order)
            0: hs(1'b1, 1'b1);
            1: begin hs(1'b0, 1'b1); hs(1'b1, 1'b0); end
            default: begin hs(1'b1, 1'b0); hs(1'b0, 1'b1); end
        endcase
        bv_now = s_bvalid; resp = s_bresp; th_now = core_tohost;
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int stall, output logic [31:0] d,
                            output logic [1:0] resp, output logic rv_now, output logic stable);
        logic ra;
        int n;
        s_araddr = a; s_arvalid = 1'b1; n = 0; ra = 1'b0;
        while (!ra && n < 64) begin
            ra = s_arready;
            tick();
            n++;
        end
        s_arvalid = 1'b0;
        if (!ra) begin
            checks++; errors++;
            $display("FAIL read_handshake_timeout: arready never seen in %0d cycles", n);
        end
        rv_now = s_rvalid; d = s_rdata; resp = s_rresp; stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (s_rvalid !== 1'b1 || s_rdata !== d || s_rresp !== resp) stable = 1'b0;
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_tohost = '0; m_coll = 1'b0; m_core_rst = 1'b1; m_fromhost = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; logic rv, st;
        logic [31:0] ed; logic [1:0] er;
        apply_reset();
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata,
             core_tohost, core_rst} !== {5'b0, 4'b0, 32'h0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: rdys %b%b%b bv %b rv %b tohost %h core_rst %b, want 0/0/0 0 0 0 1",
                     s_awready, s_wready, s_arready, s_bvalid, s_rvalid, core_tohost, core_rst);
        end
        rst = 1'b0;
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_clock: got %b want 000", {s_awready, s_wready, s_arready});
        end
        tick();
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 111", {s_awready, s_wready, s_arready});
        end
        // Core writes are ignored while the core is held in reset
        core_tohost_we = 1'b1; core_tohost_wdata = 32'hA5A5_A5A5;
        tick();
        core_tohost_we = 1'b0;
        tick();
        checks++;
        if (core_tohost !== 32'h0) begin
            errors++;
            $display("FAIL core_we_in_reset: got %h want %h", core_tohost, 32'h0);
        end
        axi_read(TA, 0, d, r, rv, st);
        exp_read(TA, ed, er);
        checks++;
        if ({rv, r, d} !== {1'b1, er, ed}) begin
            errors++;
            $display("FAIL reset_read_tohost: rv %b resp %b data %h want 1 %b %h", rv, r, d, er, ed);
        end
        axi_read(TA + 32'd4, 0, d, r, rv, st);
        checks++;
        if ({rv, r, d} !== {1'b1, 2'b00, 32'h1}) begin
            errors++;
            $display("FAIL reset_read_status: rv %b resp %b data %h want 1 00 00000001", rv, r, d);
        end
    endtask

    task automatic test_host_write();
        logic [31:0] d, th; logic [1:0] r, er; logic bv, rv, st;
        axi_write(TA, 32'hDEAD_BEEF, 4'hF, 1, r, bv, th);
        model_write(TA, 32'hDEAD_BEEF, 4'hF, er);
        checks++;
        if ({bv, r, th} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_w_first: bvalid %b bresp %b tohost %h want 1 00 deadbeef", bv, r, th);
        end
        axi_read(TA, 0, d, r, rv, st);
        checks++;
        if ({r, d} !== {2'b00, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL readback_deadbeef: resp %b data %h want 00 deadbeef", r, d);
        end
        axi_write(TA, 32'h1122_3344, 4'b0101, 2, r, bv, th);
        model_write(TA, 32'h1122_3344, 4'b0101, er);
        checks++;
        if ({bv, r, th} !== {1'b1, er, m_tohost}) begin
            errors++;
            $display("FAIL write_partial_strobe: bvalid %b bresp %b tohost %h want 1 %b %h", bv, r, th, er, m_tohost);
        end
    endtask

    task automatic test_release();
        int n;
        logic stayed;
        vdip = 16'h0001;
        repeat (10) tick();
        checks++;
        if (core_rst !== 1'b1) begin
            errors++;
            $display("FAIL release_early: core_rst %b want 1 after 10 cycles", core_rst);
        end
        vdip = 16'h0000;
        stayed = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (core_rst !== 1'b1) stayed = 1'b0;
        end
        checks++;
        if (stayed !== 1'b1) begin
            errors++;
            $display("FAIL release_abort: core_rst dropped after vdip fell, want held at 1");
        end
        vdip = 16'h0001;
        n = 0;
        while (core_rst === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2 + 1 + RST_DELAY) begin
            errors++;
            $display("FAIL release_latency: core_rst fell after %0d cycles want %0d", n, 2 + 1 + RST_DELAY);
        end
        m_core_rst = 1'b0;
    endtask

    task automatic test_core_write();
        logic [31:0] d; logic [1:0] r; logic rv, st;
        core_tohost_we = 1'b1; core_tohost_wdata = 32'h0;
        tick();
        core_tohost_we = 1'b0;
        m_tohost = 32'h0;
        checks++;
        if (core_tohost !== 32'h0) begin
            errors++;
            $display("FAIL core_write_zero: tohost %h want 00000000", core_tohost);
        end
        axi_read(TA, 0, d, r, rv, st);
        checks++;
        if ({r, d} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL host_poll_zero: resp %b data %h want 00 00000000", r, d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d, th; logic [1:0] r, er; logic rv, st, bv;
        s_awaddr = TA; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        core_tohost_we = 1'b1; core_tohost_wdata = 32'h0;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; core_tohost_we = 1'b0;
        m_tohost = 32'h1234_5678; m_coll = 1'b1;
        checks++;
        if ({s_bvalid, core_tohost} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL collision_host_wins: bvalid %b tohost %h want 1 12345678", s_bvalid, core_tohost);
        end
        s_bready = 1'b1; tick(); s_bready = 1'b0;
        axi_read(TA + 32'd4, 0, d, r, rv, st);
        checks++;
        if ({r, d} !== {2'b00, 32'h2}) begin
            errors++;
            $display("FAIL collision_status: resp %b data %h want 00 00000002", r, d);
        end
        axi_write(TA + 32'd4, 32'h2, 4'hF, 0, r, bv, th);
        model_write(TA + 32'd4, 32'h2, 4'hF, er);
        axi_read(TA + 32'd4, 0, d, r, rv, st);
        checks++;
        if ({r, d} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL collision_clear: resp %b data %h want 00 00000000", r, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old;
        old = m_tohost;
        s_araddr = TA; s_arvalid = 1'b1;
        s_awaddr = TA; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        m_tohost = 32'hCAFE_F00D;
        checks++;
        if ({s_rvalid, s_rdata, s_bvalid, core_tohost} !== {1'b1, old, 1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL simultaneous_rw: rvalid %b rdata %h bvalid %b tohost %h want 1 %h 1 cafef00d",
                     s_rvalid, s_rdata, s_bvalid, core_tohost, old);
        end
        s_rready = 1'b1; s_bready = 1'b1;
        tick();
        s_rready = 1'b0; s_bready = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [31:0] d, th; logic [1:0] r; logic rv, st, bv;
        axi_write(32'h0008_C200, $urandom, 4'hF, 0, r, bv, th);
        checks++;
        if ({bv, r, th} !== {1'b1, 2'b10, m_tohost}) begin
            errors++;
            $display("FAIL unmapped_write: bvalid %b bresp %b tohost %h want 1 10 %h", bv, r, th, m_tohost);
        end
        axi_read(32'h0008_C200, 5, d, r, rv, st);
        checks++;
        if ({rv, r, d, st} !== {1'b1, 2'b10, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL unmapped_read_stall: rv %b resp %b data %h stable %b want 1 10 00000000 1", rv, r, d, st);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, th, ed, rd; logic [1:0] r, er, rr; logic [3:0] stb;
        logic bv, rv, st;
        int op;
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: a = TA;
                1: a = TA + 32'd4;
                2: a = TA + 32'd8;
                default: a = TA + 32'h100 + ($urandom_range(0, 63) << 2);
            endcase
            a = a + 32'($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                d = $urandom; stb = 4'($urandom_range(0, 15));
                axi_write(a, d, stb, $urandom_range(0, 2), r, bv, th);
                model_write(a, d, stb, er);
                checks++;
                if ({bv, r, th} !== {1'b1, er, m_tohost}) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: addr %h bvalid %b bresp %b tohost %h want 1 %b %h",
                             it, a, bv, r, th, er, m_tohost);
                end
            end else if (op == 1) begin
                exp_read(a, ed, er);
                axi_read(a, $urandom_range(0, 2), rd, rr, rv, st);
                checks++;
                if ({rv, rr, rd, st} !== {1'b1, er, ed, 1'b1}) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: addr %h rv %b resp %b data %h stable %b want 1 %b %h 1",
                             it, a, rv, rr, rd, st, er, ed);
                end
            end else begin
                d = $urandom;
                core_tohost_we = 1'b1; core_tohost_wdata = d;
                tick();
                core_tohost_we = 1'b0;
                m_tohost = d;
                checks++;
                if (core_tohost !== m_tohost) begin
                    errors++;
                    $display("FAIL rand_core_write[%0d]: tohost %h want %h", it, core_tohost, m_tohost);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        s_awaddr = TA; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = TA; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_bvalid, s_rvalid, s_awready, core_tohost, core_rst} !== {3'b000, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_txn: bv %b rv %b awready %b tohost %h core_rst %b want 0 0 0 0 1",
                     s_bvalid, s_rvalid, s_awready, core_tohost, core_rst);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        vdip = '0; core_tohost_we = 1'b0; core_tohost_wdata = '0;
`ifdef NOVA_MAILBOX_FROMHOST_EN
        core_fromhost_clr = 1'b0;
`endif
        test_reset();
        test_host_write();
        test_release();
        test_core_write();
        test_collision();
        test_back_to_back();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
